recur_gen: RTL and testbench

RECUR_GEN -- requirements
Module: recur_gen

---
 rtl/recur_gen.sv | 132 +++++++++++++
 tb/tb_recur_gen.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/recur_gen.sv
// recur_gen: emits N_TERMS terms of the linear recurrence
//   x[0]=SEED0, x[1]=SEED1, x[k]=COEF_A*x[k-1]+COEF_B*x[k-2]
// one term per enabled cycle, with a sticky per-run overflow flag.
// Build option: define RECUR_GEN_SAT_EN to saturate out-of-range terms;
// otherwise they wrap (two's-complement truncation). ovf is the same in both.
module recur_gen #(
  parameter int                       WIDTH   = 20,
  parameter int                       N_TERMS = 32,
  parameter logic signed [7:0]        COEF_A  = 8'sd1,
  parameter logic signed [7:0]        COEF_B  = 8'sd1,
  parameter logic signed [WIDTH-1:0]  SEED0   = '0,
  parameter logic signed [WIDTH-1:0]  SEED1   = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    en,
  output logic signed [WIDTH-1:0] result,
  output logic                    valid,
  output logic [15:0]             index,
  output logic                    busy,
  output logic                    done,
  output logic                    ovf
);

  // Full-precision width: 8x WIDTH product plus one carry bit, with headroom.
  localparam int FW = WIDTH + 10;
  localparam logic [15:0] LAST = 16'(N_TERMS - 1);
  localparam logic signed [FW-1:0] MAX_F = {{(FW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [FW-1:0] MIN_F = {{(FW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state;
  logic signed [WIDTH-1:0] xm1;   // x[k-1], stored reduced value
  logic signed [WIDTH-1:0] xm2;   // x[k-2], stored reduced value

  logic signed [FW-1:0] coef_a_ext, coef_b_ext, xm1_ext, xm2_ext;
  logic signed [FW-1:0] sum_full;
  logic signed [WIDTH-1:0] sum_red;
  logic                    sum_ovf;

  function automatic logic out_of_range(input logic signed [FW-1:0] v);
    return (v > MAX_F) || (v < MIN_F);
  endfunction

  function automatic logic signed [WIDTH-1:0] reduce(input logic signed [FW-1:0] v);
`ifdef RECUR_GEN_SAT_EN
    if (v > MAX_F)      return MAX_F[WIDTH-1:0];
    else if (v < MIN_F) return MIN_F[WIDTH-1:0];
    else                return v[WIDTH-1:0];
`else
    return v[WIDTH-1:0];
`endif
  endfunction

  assign coef_a_ext = {{(FW-8){COEF_A[7]}}, COEF_A};
  assign coef_b_ext = {{(FW-8){COEF_B[7]}}, COEF_B};
  assign xm1_ext    = {{(FW-WIDTH){xm1[WIDTH-1]}}, xm1};
  assign xm2_ext    = {{(FW-WIDTH){xm2[WIDTH-1]}}, xm2};

  // Next recurrence term at full precision, then its reduced form and range flag.
  always_comb begin
    sum_full = (coef_a_ext * xm1_ext) + (coef_b_ext * xm2_ext);
    sum_red  = reduce(sum_full);
    sum_ovf  = out_of_range(sum_full);
  end

  // Control FSM with registered outputs and term history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      result <= '0;
      index  <= '0;
      valid  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      ovf    <= 1'b0;
      xm1    <= '0;
      xm2    <= '0;
    end else if ((state == IDLE || state == DONE) && start) begin
      // Accepted start: emit x[0] immediately and open a fresh run.
      state  <= RUN;
      result <= SEED0;
      index  <= '0;
      valid  <= 1'b1;
      busy   <= 1'b1;
      done   <= 1'b0;
      ovf    <= 1'b0;
      xm1    <= SEED0;
      xm2    <= '0;
    end else begin
      case (state)
        RUN: begin
          if (!en) begin
            valid <= 1'b0;
          end else if (index == LAST) begin
            state <= DONE;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (index == 16'd0) begin
            result <= SEED1;
            index  <= 16'd1;
            valid  <= 1'b1;
            xm2    <= xm1;
            xm1    <= SEED1;
          end else begin
            result <= sum_red;
            index  <= index + 16'd1;
            valid  <= 1'b1;
            ovf    <= ovf | sum_ovf;
            xm2    <= xm1;
            xm1    <= sum_red;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          valid <= 1'b0;
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_recur_gen.sv
// Directed testbench for recur_gen: default Fibonacci run, en hold,
// asynchronous reset mid-run, back-to-back runs with start held, and
// a non-default coefficient/seed instance.
module tb_recur_gen;

  logic clk;
  logic rst;
  logic start, en;
  logic signed [19:0] result;
  logic valid, busy, done, ovf;
  logic [15:0] index;

  logic start_b, en_b;
  logic signed [19:0] result_b;
  logic valid_b, busy_b, done_b, ovf_b;
  logic [15:0] index_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [19:0] exp_x [32];
  logic               exp_o [32];

  recur_gen u_dut (
    .clk(clk), .rst(rst), .start(start), .en(en),
    .result(result), .valid(valid), .index(index),
    .busy(busy), .done(done), .ovf(ovf)
  );

  recur_gen #(
    .WIDTH(20), .N_TERMS(4), .COEF_A(8'sd2), .COEF_B(-8'sd1),
    .SEED0(20'sd3), .SEED1(20'sd5)
  ) u_b (
    .clk(clk), .rst(rst), .start(start_b), .en(en_b),
    .result(result_b), .valid(valid_b), .index(index_b),
    .busy(busy_b), .done(done_b), .ovf(ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected default-parameter sequence, with wrap or saturation per build.
  task automatic build_expected();
    longint full;
    logic signed [63:0] f64;
    logic sticky;
    exp_x[0] = 20'sd0; exp_o[0] = 1'b0;
    exp_x[1] = 20'sd1; exp_o[1] = 1'b0;
    sticky = 1'b0;
    for (int k = 2; k < 32; k++) begin
      full = longint'(exp_x[k-1]) + longint'(exp_x[k-2]);
      f64  = full;
      if (full > 524287 || full < -524288) sticky = 1'b1;
`ifdef RECUR_GEN_SAT_EN
      if (full > 524287)       exp_x[k] = 20'sd524287;
      else if (full < -524288) exp_x[k] = -20'sd524288;
      else                     exp_x[k] = f64[19:0];
`else
      exp_x[k] = f64[19:0];
`endif
      exp_o[k] = sticky;
    end
  endtask

  task automatic test_reset();
    n_checks++; if (result !== 20'sd0) begin n_fail++; $display("FAIL reset_result got %0d want 0", result); end
    n_checks++; if (index !== 16'd0) begin n_fail++; $display("FAIL reset_index got %0d want 0", index); end
    n_checks++; if ({valid, busy, done, ovf} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got %b want 0000", {valid, busy, done, ovf}); end
    @(posedge clk); #1;
    rst = 1'b1;
    tick();
    n_checks++; if ({valid, busy, done} !== 3'b000) begin n_fail++; $display("FAIL idle_flags got %b want 000", {valid, busy, done}); end
  endtask

  task automatic test_sequence();
    start = 1'b1; en = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      n_checks++;
      if (result !== exp_x[k] || index !== 16'(k) || valid !== 1'b1 || ovf !== exp_o[k] || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL seq_term%0d got r=%0d i=%0d v=%b o=%b b=%b want r=%0d i=%0d v=1 o=%b b=1",
                 k, result, index, valid, ovf, busy, exp_x[k], k, exp_o[k]);
      end
      tick();
    end
    n_checks++; if (exp_x[29] !== 20'sd514229) begin n_fail++; $display("FAIL model_idx29 got %0d want 514229", exp_x[29]); end
`ifdef RECUR_GEN_SAT_EN
    n_checks++; if (exp_x[30] !== 20'sd524287 || exp_x[31] !== 20'sd524287) begin n_fail++; $display("FAIL model_sat got %0d %0d want 524287 524287", exp_x[30], exp_x[31]); end
`else
    n_checks++; if (exp_x[30] !== -20'sd216536 || exp_x[31] !== 20'sd297693) begin n_fail++; $display("FAIL model_wrap got %0d %0d want -216536 297693", exp_x[30], exp_x[31]); end
`endif
    n_checks++; if ({done, valid, busy} !== 3'b100 || index !== 16'd31) begin n_fail++; $display("FAIL seq_done got d/v/b=%b i=%0d want 100 i=31", {done, valid, busy}, index); end
    tick();
    n_checks++; if (done !== 1'b0 || result !== exp_x[31] || index !== 16'd31 || ovf !== 1'b1) begin n_fail++; $display("FAIL seq_idle_hold got d=%b r=%0d i=%0d o=%b want d=0 r=%0d i=31 o=1", done, result, index, ovf, exp_x[31]); end
  endtask

  task automatic wait_done(input string tag);
    int cnt = 0;
    while (done !== 1'b1 && cnt < 100) begin tick(); cnt++; end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL %s_timeout got done=%b want 1", tag, done); end
    tick();
  endtask

  task automatic test_en_hold();
    start = 1'b1; en = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    n_checks++; if (index !== 16'd5 || result !== 20'sd5) begin n_fail++; $display("FAIL en_pre got i=%0d r=%0d want i=5 r=5", index, result); end
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (result !== 20'sd5 || index !== 16'd5 || valid !== 1'b0) begin
        n_fail++; $display("FAIL en_hold%0d got r=%0d i=%0d v=%b want r=5 i=5 v=0", k, result, index, valid);
      end
    end
    en = 1'b1;
    tick();
    n_checks++; if (result !== 20'sd8 || index !== 16'd6 || valid !== 1'b1) begin n_fail++; $display("FAIL en_resume got r=%0d i=%0d v=%b want r=8 i=6 v=1", result, index, valid); end
    wait_done("en");
  endtask

  task automatic test_reset_mid();
    start = 1'b1; en = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    n_checks++; if (index !== 16'd10 || result !== 20'sd55) begin n_fail++; $display("FAIL rst_pre got i=%0d r=%0d want i=10 r=55", index, result); end
    rst = 1'b0;
    #2;
    n_checks++;
    if (result !== 20'sd0 || index !== 16'd0 || {valid, busy, done, ovf} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_async got r=%0d i=%0d vbdo=%b want 0 0 0000", result, index, {valid, busy, done, ovf});
    end
    tick();
    n_checks++; if (busy !== 1'b0 || index !== 16'd0) begin n_fail++; $display("FAIL rst_held got b=%b i=%0d want 0 0", busy, index); end
    rst = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (result !== 20'sd0 || index !== 16'd0 || valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL rst_restart got r=%0d i=%0d v=%b b=%b want 0 0 1 1", result, index, valid, busy); end
    tick();
    n_checks++; if (result !== 20'sd1 || index !== 16'd1) begin n_fail++; $display("FAIL rst_restart1 got r=%0d i=%0d want 1 1", result, index); end
    wait_done("rst");
  endtask

  task automatic test_back_to_back();
    start = 1'b1; en = 1'b1;
    tick();
    for (int k = 0; k < 32; k++) begin
      n_checks++;
      if (index !== 16'(k) || result !== exp_x[k]) begin
        n_fail++; $display("FAIL b2b_term%0d got i=%0d r=%0d want i=%0d r=%0d", k, index, result, k, exp_x[k]);
      end
      tick();
    end
    n_checks++; if (done !== 1'b1 || ovf !== 1'b1) begin n_fail++; $display("FAIL b2b_done got d=%b o=%b want 1 1", done, ovf); end
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1 || valid !== 1'b1 || index !== 16'd0 || result !== 20'sd0 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL b2b_restart got d=%b b=%b v=%b i=%0d r=%0d o=%b want 0 1 1 0 0 0", done, busy, valid, index, result, ovf);
    end
    start = 1'b0;
    wait_done("b2b");
  endtask

  task automatic test_coef();
    logic signed [19:0] want [4];
    want[0] = 20'sd3; want[1] = 20'sd5; want[2] = 20'sd7; want[3] = 20'sd9;
    start_b = 1'b1; en_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (result_b !== want[k] || index_b !== 16'(k) || valid_b !== 1'b1 || ovf_b !== 1'b0) begin
        n_fail++; $display("FAIL coef_term%0d got r=%0d i=%0d v=%b o=%b want r=%0d i=%0d v=1 o=0", k, result_b, index_b, valid_b, ovf_b, want[k], k);
      end
      tick();
    end
    n_checks++; if (done_b !== 1'b1 || valid_b !== 1'b0) begin n_fail++; $display("FAIL coef_done got d=%b v=%b want 1 0", done_b, valid_b); end
    tick();
    n_checks++; if (done_b !== 1'b0 || busy_b !== 1'b0) begin n_fail++; $display("FAIL coef_idle got d=%b b=%b want 0 0", done_b, busy_b); end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; en = 1'b0; start_b = 1'b0; en_b = 1'b0;
    build_expected();
    #2;
    test_reset();
    test_sequence();
    test_en_hold();
    test_reset_mid();
    test_back_to_back();
    test_coef();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
